// File: rtl/stage_sequencer.sv
// Four-stage instruction sequencer: one-hot stage enables, per-stage completion strobes,
// run/halt/single-step control and a stall hold, all registered on clk.
module stage_sequencer #(
    parameter int unsigned STAGE_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   halt_req,
    input  logic                   step_req,
    input  logic                   stall,
    output logic [0:3]             is_stage,
    output logic [0:3]             stage_done,
    output logic                   step_ack,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {
        HALTED,
        RUN,
        STEP
    } state_t;

    localparam logic [3:0] LAST_PHASE = 4'(STAGE_CYCLES - 1);

    state_t                 state, state_n;
    logic [3:0]             phase, phase_n;
    logic [0:3]             is_stage_n;
    logic [0:3]             stage_done_n;
    logic                   step_ack_n;
    logic [COUNT_WIDTH-1:0] instr_count_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HALTED;
            phase       <= '0;
            is_stage    <= 4'b1000;
            stage_done  <= '0;
            step_ack    <= 1'b0;
            halted      <= 1'b1;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            is_stage    <= is_stage_n;
            stage_done  <= stage_done_n;
            step_ack    <= step_ack_n;
            halted      <= (state_n == HALTED);
            instr_count <= instr_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        phase_n       = phase;
        is_stage_n    = is_stage;
        stage_done_n  = '0;
        step_ack_n    = 1'b0;
        instr_count_n = instr_count;

        case (state)
            HALTED: begin
                is_stage_n = 4'b1000;
                phase_n    = '0;
                if (run && !halt_req) begin
                    state_n = RUN;
                end else if (step_req) begin
                    state_n = STEP;
                end
            end
            default: begin
                if (!stall) begin
                    if (phase == LAST_PHASE) begin
                        phase_n      = '0;
                        is_stage_n   = {is_stage[3], is_stage[0:2]};
                        stage_done_n = is_stage;
                        // Leaving stage3 is the instruction boundary: retire and decide halt.
                        if (is_stage[3]) begin
                            instr_count_n = instr_count + COUNT_WIDTH'(1);
                            if (state == STEP) begin
                                state_n    = HALTED;
                                step_ack_n = 1'b1;
                            end else if (halt_req || !run) begin
                                state_n = HALTED;
                            end
                        end
                    end else begin
                        phase_n = phase + 4'd1;
                    end
                end
            end
        endcase
    end

endmodule
